// File: rtl/spi_seq_pkg.sv
// Shared types for the SPI transfer sequencer: FSM states, word-length
// encodings, the per-word configuration / TX entry layout and the MISO mask.
package spi_seq_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_XFER    = 2'd2,
    ST_CAPTURE = 2'd3
  } seq_state_e;

  localparam logic [1:0] WL_8  = 2'b00;
  localparam logic [1:0] WL_16 = 2'b01;
  localparam logic [1:0] WL_24 = 2'b10;
  localparam logic [1:0] WL_32 = 2'b11;

  // Configuration captured alongside each outgoing word.
  typedef struct packed {
    logic [1:0] spi_mode;
    logic [1:0] sck_speed;
    logic [1:0] word_len;
    logic [7:0] ifg;
    logic [7:0] cs_sck;
    logic [7:0] sck_cs;
  } xfer_cfg_t;

  typedef struct packed {
    xfer_cfg_t   cfg;
    logic [31:0] data;
  } tx_entry_t;

  // Keep only the bits the transfer actually shifted; upper bits read as zero.
  function automatic logic [31:0] mask_word(input logic [1:0] wl, input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    case (wl)
      WL_8:    r = {24'h0, d[7:0]};
      WL_16:   r = {16'h0, d[15:0]};
      WL_24:   r = {8'h0, d[23:0]};
      WL_32:   r = d;
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous FIFO with an occupancy counter. The counter (not the pointers)
// tells full from empty, so pointers simply wrap modulo DEPTH. Pushes while
// full and pops while empty are ignored. The read port shows zero when empty
// so the consumer never sees stale data after reset.
module spi_seq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LVL_FULL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage array; contents need no reset because the read port is gated by empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// SPI transfer sequencer: buffers words plus per-word config in a TX FIFO,
// launches one transfer at a time on the SPI core, and queues the masked MISO
// word in an RX FIFO.
// Optional feature macro: SPI_SEQ_XFER_CNT_EN adds a 16-bit wrapping count of
// completed transfers on xfer_cnt_out.
//
// Handshakes: a transfer on the TX side happens on a rising GCLK edge where
// tx_valid && tx_ready; on the RX side where rx_valid && rx_ready. Valid never
// depends on ready. tx_ready = !tx_full, rx_valid = !rx_empty.
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          GCLK,
  input  logic                          RST,
  input  logic                          enable_cfg,
  input  logic [1:0]                    spi_mode_cfg,
  input  logic [1:0]                    sck_speed_cfg,
  input  logic [1:0]                    word_len_cfg,
  input  logic [7:0]                    ifg_cfg,
  input  logic [7:0]                    cs_sck_cfg,
  input  logic [7:0]                    sck_cs_cfg,
  input  logic                          tx_valid,
  input  logic [31:0]                   tx_data,
  output logic                          tx_ready,
  output logic                          rx_valid,
  output logic [31:0]                   rx_data,
  input  logic                          rx_ready,
  output logic                          start_out,
  output logic [1:0]                    spi_mode_out,
  output logic [1:0]                    sck_speed_out,
  output logic [1:0]                    word_len_out,
  output logic [7:0]                    IFG_out,
  output logic [7:0]                    CS_SCK_out,
  output logic [7:0]                    SCK_CS_out,
  output logic [31:0]                   mosi_data_out,
  input  logic                          busy_in,
  input  logic [31:0]                   miso_data_in,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          idle_out
`ifdef SPI_SEQ_XFER_CNT_EN
  ,
  output logic [15:0]                   xfer_cnt_out
`endif
);

  localparam int TXW = $bits(tx_entry_t);

  seq_state_e state_q, state_d;
  tx_entry_t  tx_din;
  tx_entry_t  tx_dout;
  logic       tx_full, tx_empty, tx_pop;
  logic       rx_full, rx_empty, rx_push;
  logic [31:0] rx_din;
  logic       load;
  xfer_cfg_t  cfg_q;
  logic [31:0] mosi_q;

  // Pack the push-side inputs into one TX entry.
  always_comb begin
    tx_din               = '0;
    tx_din.cfg.spi_mode  = spi_mode_cfg;
    tx_din.cfg.sck_speed = sck_speed_cfg;
    tx_din.cfg.word_len  = word_len_cfg;
    tx_din.cfg.ifg       = ifg_cfg;
    tx_din.cfg.cs_sck    = cs_sck_cfg;
    tx_din.cfg.sck_cs    = sck_cs_cfg;
    tx_din.data          = tx_data;
  end

  spi_seq_fifo #(.WIDTH(TXW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (GCLK),
    .rst_i   (RST),
    .push_i  (tx_valid),
    .din_i   (tx_din),
    .pop_i   (tx_pop),
    .dout_o  (tx_dout),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level)
  );

  // Mask with the word length latched at launch, not the live config inputs.
  assign rx_din = mask_word(cfg_q.word_len, miso_data_in);

  spi_seq_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (GCLK),
    .rst_i   (RST),
    .push_i  (rx_push),
    .din_i   (rx_din),
    .pop_i   (rx_ready),
    .dout_o  (rx_data),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (rx_level)
  );

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;

  // FSM state register.
  always_ff @(posedge GCLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state and control strobes. RX space is checked before launch so
  // the CAPTURE push can never hit a full RX FIFO.
  always_comb begin
    state_d   = state_q;
    tx_pop    = 1'b0;
    load      = 1'b0;
    rx_push   = 1'b0;
    start_out = 1'b0;
    idle_out  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idle_out = tx_empty;
        if (enable_cfg && !tx_empty && !rx_full && !busy_in) begin
          tx_pop  = 1'b1;
          load    = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        start_out = 1'b1;
        if (busy_in) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (!busy_in) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        rx_push = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Core-side config and MOSI registers: held from one launch to the next.
  always_ff @(posedge GCLK) begin
    if (RST) begin
      cfg_q  <= '0;
      mosi_q <= '0;
    end else if (load) begin
      cfg_q  <= tx_dout.cfg;
      mosi_q <= tx_dout.data;
    end
  end

  assign spi_mode_out  = cfg_q.spi_mode;
  assign sck_speed_out = cfg_q.sck_speed;
  assign word_len_out  = cfg_q.word_len;
  assign IFG_out       = cfg_q.ifg;
  assign CS_SCK_out    = cfg_q.cs_sck;
  assign SCK_CS_out    = cfg_q.sck_cs;
  assign mosi_data_out = mosi_q;

`ifdef SPI_SEQ_XFER_CNT_EN
  logic [15:0] xfer_cnt_q;

  // Completed-transfer counter, bumped once per CAPTURE and wrapping at 16 bits.
  always_ff @(posedge GCLK) begin
    if (RST)                        xfer_cnt_q <= '0;
    else if (state_q == ST_CAPTURE) xfer_cnt_q <= xfer_cnt_q + 16'd1;
  end

  assign xfer_cnt_out = xfer_cnt_q;
`endif

endmodule
